// File: rtl/mips_reg_file_if.sv
// Register-file port bundle: write port, two read ports, debug read and $0-write flag.
interface mips_reg_file_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              wr_zero_err;

  // Datapath side: drives addresses and write data, consumes read data.
  modport master (
    output we, wa, wd, ra1, ra2, dbg_addr,
    input  rd1, rd2, dbg_data, wr_zero_err
  );

  // Register-file side.
  modport slave (
    input  we, wa, wd, ra1, ra2, dbg_addr,
    output rd1, rd2, dbg_data, wr_zero_err
  );
endinterface

// File: rtl/mips_reg_file.sv
// 32 x 32 MIPS GPR file: two combinational read ports, one synchronous write
// port, $0 hardwired to zero, optional write-through on the read ports.
module mips_reg_file #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       BYPASS  = 0,
  parameter logic [DATA_W-1:0] SP_INIT = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_reg_file_if.slave    bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned SP_IDX = 29;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              zero_err_q;
  logic              wr_en_c;
  logic              bypass_en_c;

  // A write only lands outside reset and never on $0.
  assign wr_en_c     = bus.we && (bus.wa != '0);
  assign bypass_en_c = (BYPASS != 0) && rst_n && wr_en_c;

  // Storage: async reset to zero ($sp to SP_INIT), then one write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[ADDR_W'(i)] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_en_c) begin
      regs[bus.wa] <= bus.wd;
    end
  end

  // Flag a write attempt to $0 for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= bus.we && (bus.wa == '0);
    end
  end

  // Stored value of a register, with $0 forced to zero.
  function automatic logic [DATA_W-1:0] stored(input logic [ADDR_W-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  // Read ports: stored value, or wd when write-through is enabled and addresses match.
  always_comb begin
    bus.rd1 = stored(bus.ra1);
    bus.rd2 = stored(bus.ra2);
    if (bypass_en_c && (bus.ra1 == bus.wa)) bus.rd1 = bus.wd;
    if (bypass_en_c && (bus.ra2 == bus.wa)) bus.rd2 = bus.wd;
  end

  // Debug port never bypasses.
  assign bus.dbg_data    = stored(bus.dbg_addr);
  assign bus.wr_zero_err = zero_err_q;

endmodule
